multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the multi-cycle MIPS datapath: fetch, decode, execute, memory, writeback.
//  Drives every datapath mux/enable, including ext_sel to the immediate extender
//  (sign-extend for arith/mem/branch; zero-extend for logical immediates).
//  Waits on the memory ready handshake and times out hung accesses.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles a FETCH/MEM_READ/MEM_WRITE waits for mem_ready before bus_error
//  LOGIC_ZEXT    1   1: andi/ori use zero-extension (ext_sel=0); 0: all immediates sign-extended
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous reset, active-high
//  opcode       in   6  instr[31:26] from instruction register
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes access this cycle
//  pc_en        out  1  PC load: unconditional, or taken branch (beq: zero, bne: !zero)
//  i_or_d       out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  load instruction register
//  reg_dst      out  1  0: rt, 1: rd
//  mem_to_reg   out  1  0: ALUOut, 1: MDR
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0: PC, 1: rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  alu_op       out  2  00 add, 01 sub, 10 funct-decode, 11 opcode-decode (I-type)
//  pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  ext_sel      out  1  1: sign-extend imm16, 0: zero-extend
//  bus_error    out  1  sticky; set on mem_ready timeout, cleared only by rst
//  illegal_op   out  1  one-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
//  rst: state=IDLE, wait counter=0, bus_error=0; all outputs 0 in IDLE. IDLE->FETCH unconditionally next cycle.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//   ir_write and pc_en asserted only in the cycle mem_ready=1, then ->DECODE; else stay, counter++.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_sel=1 (branch target precompute). Dispatch:
//   100011/101011 ->MEM_ADDR; 000000 ->EXEC_R; 000100/000101 ->BRANCH;
//   001000/001010/001100/001101 ->EXEC_I; else illegal_op=1, ->FETCH (instruction skipped).
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_sel=1; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD: mem_read=1, i_or_d=1; ->MEM_WB on mem_ready. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; ->FETCH on mem_ready.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 ->R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11; ext_sel=0 for andi/ori when LOGIC_ZEXT=1, else 1.
//   ->I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_en=zero (beq) or !zero (bne); ->FETCH.
//  ext_sel is 1 in every state not listed above; opcode is held stable by IR outside FETCH.
//  Wait counter: counts cycles in a waiting state with mem_ready=0, clears on state change.
//   Reaching MEM_WAIT_MAX with mem_ready still 0: bus_error<=1, ->HALT. HALT: all outputs 0; left only by rst.
//   mem_ready=1 on the same cycle the count hits MEM_WAIT_MAX: access completes, no error.
//  rst mid-access: outputs drop to 0 asynchronously; no partial reg_write or mem_write is issued.
//  Latency with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, branch 3.
// CONFIGURATION
//  MCC_JUMP_EN defined: opcode 000010 (j) decodes ->JUMP: pc_en=1, pc_source=10; ->FETCH (3 cycles).
//  MCC_JUMP_EN undefined: 000010 is illegal (illegal_op pulse); pc_source never drives 10; no JUMP state.
// TESTING
//  rst high 3 cycles, release, mem_ready=1 -> IDLE 1 cycle, FETCH with mem_read=1 and ir_write=1 next.
//  ori (001101) with LOGIC_ZEXT=1 -> EXEC_I ext_sel=0, I_WB reg_write=1 reg_dst=0; addi -> ext_sel=1; 4 cycles each.
//  lw, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with mem_to_reg=1.
//  beq with zero=1 -> pc_en=1, pc_source=01; bne with zero=1 -> pc_en=0; both return to FETCH.
//  mem_ready held 0 in FETCH -> bus_error=1 after 15 cycles, HALT with all outputs 0 until rst.
//  opcode 000010: with MCC_JUMP_EN pc_en=1 pc_source=10; without it illegal_op=1 for 1 cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath, with memory-ready timeout and sticky bus_error.
// Optional build macro MCC_JUMP_EN adds the j (000010) instruction through a JUMP state.
module multicycle_controller #(
   parameter int MEM_WAIT_MAX = 15,
   parameter bit LOGIC_ZEXT   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       ext_sel,
   output logic       bus_error,
   output logic       illegal_op
);

   localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_HALT
`ifdef MCC_JUMP_EN
      , S_JUMP
`endif
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;
   logic             timeout;

   // The wait counter only runs while parked in a memory state; any state change restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         bus_error <= 1'b0;
      end else begin
         state <= state_next;
         if (timeout)
            bus_error <= 1'b1;
         if (state_next != state)
            wait_cnt <= '0;
         else if (waiting && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      waiting    = 1'b0;
      timeout    = 1'b0;
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      ext_sel    = 1'b1;
      illegal_op = 1'b0;
      case (state)
         S_IDLE: begin
            ext_sel    = 1'b0;
            state_next = S_FETCH;
         end
         S_FETCH: begin
            waiting   = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_en      = 1'b1;
               state_next = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout    = 1'b1;
               state_next = S_HALT;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW:                    state_next = S_MEM_ADDR;
               OP_RTYPE:                        state_next = S_EXEC_R;
               OP_BEQ, OP_BNE:                  state_next = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
`ifdef MCC_JUMP_EN
               OP_J:                            state_next = S_JUMP;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            waiting  = 1'b1;
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_next = S_MEM_WB;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout    = 1'b1;
               state_next = S_HALT;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            waiting   = 1'b1;
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               state_next = S_FETCH;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout    = 1'b1;
               state_next = S_HALT;
            end
         end
         S_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            state_next = S_FETCH;
         end
         // Logical immediates take the zero-extended operand when LOGIC_ZEXT is set.
         S_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = 2'b11;
            if (LOGIC_ZEXT && (opcode == OP_ANDI || opcode == OP_ORI))
               ext_sel = 1'b0;
            state_next = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_source  = 2'b01;
            pc_en      = (opcode == OP_BNE) ? !zero : zero;
            state_next = S_FETCH;
         end
`ifdef MCC_JUMP_EN
         S_JUMP: begin
            pc_en      = 1'b1;
            pc_source  = 2'b10;
            state_next = S_FETCH;
         end
`endif
         S_HALT: begin
            ext_sel    = 1'b0;
            state_next = S_HALT;
         end
         default: begin
            ext_sel    = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class, memory stalls,
// the timeout boundary, HALT and asynchronous reset. Follows MCC_JUMP_EN like the design.
module tb_multicycle_controller;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, ext_sel, bus_error, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [18:0] outv;

   int checks = 0;
   int errors = 0;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .ext_sel(ext_sel), .bus_error(bus_error), .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outv = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, ext_sel, bus_error, illegal_op};

   // Bit order: pc_en i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
   //            | alu_src_b | alu_op | pc_source | ext_sel bus_error illegal_op
   localparam logic [18:0] E_IDLE     = 19'b000000000_00_00_00_000;
   localparam logic [18:0] E_FETCH    = 19'b101010000_01_00_00_100;
   localparam logic [18:0] E_FETCH_W  = 19'b001000000_01_00_00_100;
   localparam logic [18:0] E_DECODE   = 19'b000000000_11_00_00_100;
   localparam logic [18:0] E_DEC_ILL  = 19'b000000000_11_00_00_101;
   localparam logic [18:0] E_MEM_ADDR = 19'b000000001_10_00_00_100;
   localparam logic [18:0] E_MEM_RD   = 19'b011000000_00_00_00_100;
   localparam logic [18:0] E_MEM_WB   = 19'b000000110_00_00_00_100;
   localparam logic [18:0] E_MEM_WR   = 19'b010100000_00_00_00_100;
   localparam logic [18:0] E_EXEC_R   = 19'b000000001_00_10_00_100;
   localparam logic [18:0] E_R_WB     = 19'b000001010_00_00_00_100;
   localparam logic [18:0] E_EXEC_IS  = 19'b000000001_10_11_00_100;
   localparam logic [18:0] E_EXEC_IZ  = 19'b000000001_10_11_00_000;
   localparam logic [18:0] E_I_WB     = 19'b000000010_00_00_00_100;
   localparam logic [18:0] E_BR_TAKE  = 19'b100000001_00_01_01_100;
   localparam logic [18:0] E_BR_SKIP  = 19'b000000001_00_01_01_100;
   localparam logic [18:0] E_HALT     = 19'b000000000_00_00_00_010;
`ifdef MCC_JUMP_EN
   localparam logic [18:0] E_JUMP     = 19'b100000000_00_00_10_100;
`endif

   task automatic checkOutput(input string tag, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic z);
      opcode    = op;
      mem_ready = rdy;
      zero      = z;
   endtask

   // Sample mid-cycle, then advance to just after the next rising edge.
   task automatic cycle(input string tag, input logic [18:0] exp);
      @(negedge clk);
      checkOutput(tag, outv, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(6'b001101, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset", outv, E_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle("idle", E_IDLE);

      // ori: zero-extended immediate, 4 cycles
      cycle("ori_fetch", E_FETCH);
      cycle("ori_decode", E_DECODE);
      cycle("ori_exec", E_EXEC_IZ);
      cycle("ori_wb", E_I_WB);

      applyStimulus(6'b001000, 1'b1, 1'b0);
      cycle("addi_fetch", E_FETCH);
      cycle("addi_decode", E_DECODE);
      cycle("addi_exec", E_EXEC_IS);
      cycle("addi_wb", E_I_WB);

      applyStimulus(6'b000000, 1'b1, 1'b0);
      cycle("r_fetch", E_FETCH);
      cycle("r_decode", E_DECODE);
      cycle("r_exec", E_EXEC_R);
      cycle("r_wb", E_R_WB);

      // lw with three stall cycles in MEM_RD
      applyStimulus(6'b100011, 1'b1, 1'b0);
      cycle("lw_fetch", E_FETCH);
      cycle("lw_decode", E_DECODE);
      cycle("lw_addr", E_MEM_ADDR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle("lw_rd_wait", E_MEM_RD);
      mem_ready = 1'b1;
      cycle("lw_rd_done", E_MEM_RD);
      cycle("lw_wb", E_MEM_WB);

      applyStimulus(6'b101011, 1'b1, 1'b0);
      cycle("sw_fetch", E_FETCH);
      cycle("sw_decode", E_DECODE);
      cycle("sw_addr", E_MEM_ADDR);
      cycle("sw_wr", E_MEM_WR);

      applyStimulus(6'b000100, 1'b1, 1'b1);
      cycle("beq_fetch", E_FETCH);
      cycle("beq_decode", E_DECODE);
      cycle("beq_z1_taken", E_BR_TAKE);

      applyStimulus(6'b000101, 1'b1, 1'b1);
      cycle("bne_fetch", E_FETCH);
      cycle("bne_decode", E_DECODE);
      cycle("bne_z1_skip", E_BR_SKIP);

      applyStimulus(6'b000101, 1'b1, 1'b0);
      cycle("bne2_fetch", E_FETCH);
      cycle("bne2_decode", E_DECODE);
      cycle("bne_z0_taken", E_BR_TAKE);

      applyStimulus(6'b000100, 1'b1, 1'b0);
      cycle("beq2_fetch", E_FETCH);
      cycle("beq2_decode", E_DECODE);
      cycle("beq_z0_skip", E_BR_SKIP);

      applyStimulus(6'b111111, 1'b1, 1'b0);
      cycle("ill_fetch", E_FETCH);
      cycle("ill_decode", E_DEC_ILL);

      applyStimulus(6'b000010, 1'b1, 1'b0);
      cycle("j_fetch", E_FETCH);
`ifdef MCC_JUMP_EN
      cycle("j_decode", E_DECODE);
      cycle("j_jump", E_JUMP);
`else
      cycle("j_decode_ill", E_DEC_ILL);
`endif

      // 14 stalled fetch cycles then ready on the 15th: completes without error
      applyStimulus(6'b000000, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) cycle("edge_fetch_wait", E_FETCH_W);
      mem_ready = 1'b1;
      cycle("edge_fetch_done", E_FETCH);
      cycle("edge_decode", E_DECODE);
      cycle("edge_exec", E_EXEC_R);
      cycle("edge_wb", E_R_WB);

      // 15 stalled fetch cycles: timeout into HALT
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) cycle("to_fetch_wait", E_FETCH_W);
      cycle("halt", E_HALT);
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle("halt_hold", E_HALT);

      // Asynchronous reset in the middle of a stalled load
      rst = 1'b1;
      #2;
      checkOutput("rst_from_halt", outv, E_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(6'b100011, 1'b1, 1'b0);
      cycle("idle2", E_IDLE);
      cycle("lw2_fetch", E_FETCH);
      cycle("lw2_decode", E_DECODE);
      cycle("lw2_addr", E_MEM_ADDR);
      mem_ready = 1'b0;
      cycle("lw2_rd_wait", E_MEM_RD);
      rst = 1'b1;
      #2;
      checkOutput("rst_mid_access", outv, E_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      cycle("idle3", E_IDLE);
      cycle("fetch_after_rst", E_FETCH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
